// File: rtl/line_pkg.sv
// Shared types for the tile-line display path: tile codes and tile geometry.
package line_pkg;

    typedef enum logic [1:0] {
        CODE_BLANK = 2'd0,
        CODE_RIGHT = 2'd1,
        CODE_LEFT  = 2'd2,
        CODE_RESV  = 2'd3
    } code_t;

    localparam int TILE_W = 8;
    localparam int TILE_H = 8;

endpackage

// File: rtl/line_rom.sv
// Glyph ROM: 8x8 tile rows addressed by {code, row}; bit 7 is the leftmost pixel.
module line_rom
    import line_pkg::*;
(
    input  logic [4:0] addr_i,
    output logic [7:0] data_o
);

    code_t code;

    always_comb begin
        code   = code_t'(addr_i[4:3]);
        data_o = 8'h00;
        // Vertical strokes on either tile edge; BLANK and RESV stay empty.
        case (code)
            CODE_RIGHT: data_o = 8'b0000_0001;
            CODE_LEFT:  data_o = 8'b1000_0000;
            default:    data_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/line_tile_renderer.sv
// Maps DrawX/DrawY onto a grid of 8x8 tiles, looks up the glyph bit via line_rom
// and produces registered pixel_on/highlight/in_grid with a fixed 2-cycle latency.
module line_tile_renderer
    import line_pkg::*;
#(
    parameter int ORIGIN_X = 64,
    parameter int ORIGIN_Y = 96,
    parameter int TILES_X  = 16,
    parameter int TILES_Y  = 8,
    parameter int MAP_AW   = 7
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank_n,
    input  logic              map_we,
    input  logic [MAP_AW-1:0] map_waddr,
    input  logic [1:0]        map_wdata,
    input  logic              step_tick,
    input  logic              step_clr,
    output logic [3:0]        step_pos,
    output logic              pixel_on,
    output logic              highlight,
    output logic              in_grid
);

    localparam int          MAP_N = TILES_X * TILES_Y;
    localparam logic [9:0]  X_LO  = 10'(ORIGIN_X);
    localparam logic [9:0]  X_HI  = 10'(ORIGIN_X + TILE_W * TILES_X);
    localparam logic [9:0]  Y_LO  = 10'(ORIGIN_Y);
    localparam logic [9:0]  Y_HI  = 10'(ORIGIN_Y + TILE_H * TILES_Y);
    localparam logic [3:0]  STEP_LAST = 4'(TILES_X - 1);

    code_t             map_q [MAP_N];
    logic [3:0]        step_q;

    logic [9:0]        dx, dy;
    logic [6:0]        tx, ty;
    logic              grid_hit;
    logic [MAP_AW-1:0] map_ridx;
    code_t             code_d;

    code_t             code_q;
    logic [2:0]        py_q, px_q;
    logic              in_grid1_q, blank1_q, col_hit_q;

    logic [7:0]        rom_data;
    logic              pixel_on_q, highlight_q, in_grid_q;

    always_comb begin
        dx       = DrawX - X_LO;
        dy       = DrawY - Y_LO;
        tx       = dx[9:3];
        ty       = dy[9:3];
        grid_hit = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
        map_ridx = MAP_AW'(int'(ty) * TILES_X + int'(tx));
        code_d   = grid_hit ? map_q[map_ridx] : CODE_BLANK;
    end

    // Tile map: the read above sees the pre-write contents, so a same-cycle
    // read of the entry being written returns the old code.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < MAP_N; i++) map_q[i] <= CODE_BLANK;
        end else if (map_we && (int'(map_waddr) < MAP_N)) begin
            map_q[map_waddr] <= code_t'(map_wdata);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            step_q <= '0;
        end else if (step_clr) begin
            step_q <= '0;
        end else if (step_tick) begin
            step_q <= (step_q == STEP_LAST) ? 4'd0 : step_q + 4'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            code_q     <= CODE_BLANK;
            py_q       <= '0;
            px_q       <= '0;
            in_grid1_q <= 1'b0;
            blank1_q   <= 1'b0;
            col_hit_q  <= 1'b0;
        end else begin
            code_q     <= code_d;
            py_q       <= dy[2:0];
            px_q       <= dx[2:0];
            in_grid1_q <= grid_hit;
            blank1_q   <= blank_n;
            col_hit_q  <= (tx == 7'(step_q));
        end
    end

    line_rom u_line_rom (
        .addr_i ({code_q, py_q}),
        .data_o (rom_data)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_on_q  <= 1'b0;
            highlight_q <= 1'b0;
            in_grid_q   <= 1'b0;
        end else begin
            pixel_on_q  <= rom_data[3'd7 - px_q] & in_grid1_q & blank1_q;
            highlight_q <= col_hit_q & in_grid1_q & blank1_q;
            in_grid_q   <= in_grid1_q & blank1_q;
        end
    end

    assign step_pos  = step_q;
    assign pixel_on  = pixel_on_q;
    assign highlight = highlight_q;
    assign in_grid   = in_grid_q;

endmodule

// File: tb/tb_line_tile_renderer.sv
// Directed bench for line_tile_renderer: grid sweep, glyph lookup, playhead,
// highlight/blanking, same-cycle map read/write and mid-line reset.
module tb_line_tile_renderer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [9:0] DrawX, DrawY;
    logic       blank_n;
    logic       map_we;
    logic [6:0] map_waddr;
    logic [1:0] map_wdata;
    logic       step_tick, step_clr;
    logic [3:0] step_pos;
    logic       pixel_on, highlight, in_grid;

    int errors = 0;
    int checks = 0;

    line_tile_renderer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank_n   (blank_n),
        .map_we    (map_we),
        .map_waddr (map_waddr),
        .map_wdata (map_wdata),
        .step_tick (step_tick),
        .step_clr  (step_clr),
        .step_pos  (step_pos),
        .pixel_on  (pixel_on),
        .highlight (highlight),
        .in_grid   (in_grid)
    );

    always #5 Clk = ~Clk;

    // Present one pixel and wait for it to emerge from the 2-stage pipe.
    task automatic pix(input int x, input int y);
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge Clk);
        @(posedge Clk);
        #1;
    endtask

    task automatic map_write(input int idx, input int code);
        @(negedge Clk);
        map_we    = 1'b1;
        map_waddr = 7'(idx);
        map_wdata = 2'(code);
        @(negedge Clk);
        map_we    = 1'b0;
    endtask

    task automatic tick(input logic clr);
        @(negedge Clk);
        step_tick = 1'b1;
        step_clr  = clr;
        @(negedge Clk);
        step_tick = 1'b0;
        step_clr  = 1'b0;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; DrawX = 10'd100; DrawY = 10'd100; blank_n = 1'b1;
        map_we = 1'b0; map_waddr = '0; map_wdata = '0;
        step_tick = 1'b0; step_clr = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({pixel_on, highlight, in_grid, step_pos} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 0000000", {pixel_on, highlight, in_grid, step_pos});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_sweep;
        logic e_grid [2];
        int   n = 0, bad_grid = 0, bad_pix = 0, fx = 0, fy = 0;
        logic exp_g;
        for (int y = 94; y < 162; y++) begin
            for (int x = 62; x < 194; x++) begin
                @(negedge Clk);
                if (n >= 2) begin
                    if (in_grid !== e_grid[1]) begin
                        if (bad_grid == 0) begin fx = x; fy = y; end
                        bad_grid++;
                    end
                    if (pixel_on !== 1'b0) bad_pix++;
                end
                exp_g = (x >= 64) && (x < 192) && (y >= 96) && (y < 160);
                e_grid[1] = e_grid[0];
                e_grid[0] = exp_g;
                DrawX = 10'(x);
                DrawY = 10'(y);
                n++;
            end
        end
        repeat (2) begin
            @(negedge Clk);
            if (in_grid !== e_grid[1]) bad_grid++;
            if (pixel_on !== 1'b0) bad_pix++;
            e_grid[1] = e_grid[0];
        end
        checks++;
        if (bad_grid !== 0) begin
            errors++;
            $display("FAIL sweep_in_grid: %0d wrong pixels (first seen near x=%0d y=%0d), want 0", bad_grid, fx, fy);
        end
        checks++;
        if (bad_pix !== 0) begin
            errors++;
            $display("FAIL sweep_pixel_on: %0d lit pixels on blank map, want 0", bad_pix);
        end
    endtask

    task automatic test_right_glyph;
        map_write(2 * 16 + 3, 1);
        pix(64 + 31, 96 + 16);
        checks++;
        if ({pixel_on, in_grid, highlight} !== 3'b110) begin
            errors++;
            $display("FAIL right_px7: got on/grid/hl=%b, want 110", {pixel_on, in_grid, highlight});
        end
        pix(64 + 30, 96 + 16);
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++;
            $display("FAIL right_px6: got %b, want 0", pixel_on);
        end
    endtask

    task automatic test_left_glyph;
        map_write(0, 2);
        for (int y = 96; y < 104; y++) begin
            pix(64, y);
            checks++;
            if (pixel_on !== 1'b1) begin
                errors++;
                $display("FAIL left_row%0d: got %b, want 1", y - 96, pixel_on);
            end
        end
        pix(63, 96);
        checks++;
        if ({in_grid, pixel_on} !== 2'b00) begin
            errors++;
            $display("FAIL left_outside: got grid/on=%b, want 00", {in_grid, pixel_on});
        end
    endtask

    task automatic test_playhead;
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0);
            checks++;
            if (step_pos !== 4'(i % 16)) begin
                errors++;
                $display("FAIL step_%0d: got %0d, want %0d", i, step_pos, i % 16);
            end
        end
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        checks++;
        if (step_pos !== 4'd0) begin
            errors++;
            $display("FAIL step_clr_wins: got %0d, want 0", step_pos);
        end
    endtask

    task automatic test_highlight;
        repeat (5) tick(1'b0);
        checks++;
        if (step_pos !== 4'd5) begin
            errors++;
            $display("FAIL step_set5: got %0d, want 5", step_pos);
        end
        pix(64 + 40, 96);
        checks++;
        if ({highlight, in_grid, pixel_on} !== 3'b110) begin
            errors++;
            $display("FAIL highlight_col5: got hl/grid/on=%b, want 110", {highlight, in_grid, pixel_on});
        end
        pix(64 + 48, 96);
        checks++;
        if (highlight !== 1'b0) begin
            errors++;
            $display("FAIL highlight_col6: got %b, want 0", highlight);
        end
        blank_n = 1'b0;
        pix(64 + 40, 96);
        checks++;
        if ({highlight, in_grid, pixel_on} !== 3'b000) begin
            errors++;
            $display("FAIL blanked: got hl/grid/on=%b, want 000", {highlight, in_grid, pixel_on});
        end
        pix(64, 96);
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++;
            $display("FAIL blanked_glyph: got %b, want 0", pixel_on);
        end
        blank_n = 1'b1;
    endtask

    task automatic test_rw_same_entry;
        @(negedge Clk);
        DrawX = 10'(64 + 31); DrawY = 10'd96;
        map_we = 1'b1; map_waddr = 7'd3; map_wdata = 2'd1;
        @(negedge Clk);
        map_we = 1'b0;
        @(negedge Clk);
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++;
            $display("FAIL rw_old_code: got %b, want 0", pixel_on);
        end
        @(negedge Clk);
        checks++;
        if (pixel_on !== 1'b1) begin
            errors++;
            $display("FAIL rw_new_code: got %b, want 1", pixel_on);
        end
        map_write(127, 0);
        pix(64 + 31, 96);
        checks++;
        if (pixel_on !== 1'b1) begin
            errors++;
            $display("FAIL idx127_keeps_idx3: got %b, want 1", pixel_on);
        end
        pix(64 + 127, 96 + 63);
        checks++;
        if ({pixel_on, in_grid} !== 2'b01) begin
            errors++;
            $display("FAIL idx127_blank: got on/grid=%b, want 01", {pixel_on, in_grid});
        end
    endtask

    task automatic test_midline_reset;
        pix(64 + 31, 96);
        tick(1'b0);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({pixel_on, in_grid, step_pos} !== 6'b0) begin
            errors++;
            $display("FAIL reset_immediate: got %b, want 000000", {pixel_on, in_grid, step_pos});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (in_grid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_1: got %b, want 0", in_grid);
        end
        @(posedge Clk); #1;
        checks++;
        if ({in_grid, pixel_on} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_2: got grid/on=%b, want 10 (map cleared)", {in_grid, pixel_on});
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_right_glyph();
        test_left_glyph();
        test_playhead();
        test_highlight();
        test_rw_same_entry();
        test_midline_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
